// File: rtl/tl_client_arbiter.sv
// rtl/tl_client_arbiter.sv - two-client TL-UL A-channel arbiter with burst lock, D routing and in-flight limit
module tl_client_arbiter #(
    parameter int MAX_INFLIGHT = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_0_a_ready,
    input  logic        auto_in_0_a_valid,
    input  logic [2:0]  auto_in_0_a_bits_opcode,
    input  logic [2:0]  auto_in_0_a_bits_size,
    input  logic        auto_in_0_a_bits_source,
    input  logic [35:0] auto_in_0_a_bits_address,
    input  logic [7:0]  auto_in_0_a_bits_mask,
    input  logic [63:0] auto_in_0_a_bits_data,
    input  logic        auto_in_0_d_ready,
    output logic        auto_in_0_d_valid,
    output logic [2:0]  auto_in_0_d_bits_opcode,
    output logic [2:0]  auto_in_0_d_bits_size,
    output logic        auto_in_0_d_bits_source,
    output logic [63:0] auto_in_0_d_bits_data,
    output logic        auto_in_1_a_ready,
    input  logic        auto_in_1_a_valid,
    input  logic [2:0]  auto_in_1_a_bits_opcode,
    input  logic [2:0]  auto_in_1_a_bits_size,
    input  logic        auto_in_1_a_bits_source,
    input  logic [35:0] auto_in_1_a_bits_address,
    input  logic [7:0]  auto_in_1_a_bits_mask,
    input  logic [63:0] auto_in_1_a_bits_data,
    input  logic        auto_in_1_d_ready,
    output logic        auto_in_1_d_valid,
    output logic [2:0]  auto_in_1_d_bits_opcode,
    output logic [2:0]  auto_in_1_d_bits_size,
    output logic        auto_in_1_d_bits_source,
    output logic [63:0] auto_in_1_d_bits_data,
    input  logic        auto_out_a_ready,
    output logic        auto_out_a_valid,
    output logic [2:0]  auto_out_a_bits_opcode,
    output logic [2:0]  auto_out_a_bits_size,
    output logic [1:0]  auto_out_a_bits_source,
    output logic [35:0] auto_out_a_bits_address,
    output logic [7:0]  auto_out_a_bits_mask,
    output logic [63:0] auto_out_a_bits_data,
    output logic        auto_out_d_ready,
    input  logic        auto_out_d_valid,
    input  logic [2:0]  auto_out_d_bits_opcode,
    input  logic [2:0]  auto_out_d_bits_size,
    input  logic [1:0]  auto_out_d_bits_source,
    input  logic [63:0] auto_out_d_bits_data
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);

    logic       lock;
    logic       lock_idx;
    logic       rr_ptr;
    logic [2:0] beat_cnt;
    logic [2:0] inflight [2];
    logic [2:0] d_cnt    [2];

    logic       elig [2];
    logic       grant;
    logic       grant_elig;
    logic       a_fire;
    logic [2:0] a_beats_m1;
    logic [2:0] d_beats_m1;
    logic       d_route;
    logic       d_fire [2];
    logic       d_last [2];
    logic       a_inc  [2];
    logic       d_dec  [2];

    // Beats minus one: 2^(size-3) beats for data-carrying messages wider than the bus.
    function automatic logic [2:0] beats_m1(input logic has_data, input logic [2:0] size);
        logic [3:0] n;
        n = 4'd1 << (size - 3'd3);
        if (has_data && size > 3'd3) begin
            return 3'(n - 4'd1);
        end
        return 3'd0;
    endfunction

    always_comb begin
        elig[0] = auto_in_0_a_valid & (lock ? (lock_idx == 1'b0) : (inflight[0] < MAX_CNT));
        elig[1] = auto_in_1_a_valid & (lock ? (lock_idx == 1'b1) : (inflight[1] < MAX_CNT));
        if (lock) begin
            grant = lock_idx;
        end else if (elig[0] && elig[1]) begin
            grant = rr_ptr;
        end else begin
            grant = elig[1];
        end
        grant_elig = grant ? elig[1] : elig[0];
    end

    assign auto_out_a_valid  = ~reset & grant_elig;
    assign auto_in_0_a_ready = ~reset & auto_out_a_ready & (grant == 1'b0) & elig[0];
    assign auto_in_1_a_ready = ~reset & auto_out_a_ready & (grant == 1'b1) & elig[1];
    assign a_fire            = auto_out_a_valid & auto_out_a_ready;

    assign auto_out_a_bits_opcode  = grant ? auto_in_1_a_bits_opcode  : auto_in_0_a_bits_opcode;
    assign auto_out_a_bits_size    = grant ? auto_in_1_a_bits_size    : auto_in_0_a_bits_size;
    assign auto_out_a_bits_address = grant ? auto_in_1_a_bits_address : auto_in_0_a_bits_address;
    assign auto_out_a_bits_mask    = grant ? auto_in_1_a_bits_mask    : auto_in_0_a_bits_mask;
    assign auto_out_a_bits_data    = grant ? auto_in_1_a_bits_data    : auto_in_0_a_bits_data;
    assign auto_out_a_bits_source  = {grant, grant ? auto_in_1_a_bits_source : auto_in_0_a_bits_source};

    assign a_beats_m1 = beats_m1(auto_out_a_bits_opcode == 3'd0 || auto_out_a_bits_opcode == 3'd1,
                                 auto_out_a_bits_size);
    assign d_beats_m1 = beats_m1(auto_out_d_bits_opcode == 3'd1, auto_out_d_bits_size);

    // D path is purely combinational: route on source[1], restore the client's own source bit.
    assign d_route           = auto_out_d_bits_source[1];
    assign auto_out_d_ready  = ~reset & (d_route ? auto_in_1_d_ready : auto_in_0_d_ready);
    assign auto_in_0_d_valid = ~reset & auto_out_d_valid & ~d_route;
    assign auto_in_1_d_valid = ~reset & auto_out_d_valid & d_route;
    assign auto_in_0_d_bits_opcode = auto_out_d_bits_opcode;
    assign auto_in_1_d_bits_opcode = auto_out_d_bits_opcode;
    assign auto_in_0_d_bits_size   = auto_out_d_bits_size;
    assign auto_in_1_d_bits_size   = auto_out_d_bits_size;
    assign auto_in_0_d_bits_source = auto_out_d_bits_source[0];
    assign auto_in_1_d_bits_source = auto_out_d_bits_source[0];
    assign auto_in_0_d_bits_data   = auto_out_d_bits_data;
    assign auto_in_1_d_bits_data   = auto_out_d_bits_data;

    always_comb begin
        d_fire[0] = auto_in_0_d_valid & auto_in_0_d_ready;
        d_fire[1] = auto_in_1_d_valid & auto_in_1_d_ready;
        for (int k = 0; k < 2; k++) begin
            d_last[k] = d_fire[k] & ((d_cnt[k] == 3'd1) || (d_cnt[k] == 3'd0 && d_beats_m1 == 3'd0));
            a_inc[k]  = a_fire & ~lock & (grant == k[0]);
            // A stray response with nothing outstanding must not wrap the counter.
            d_dec[k]  = d_last[k] & (inflight[k] != 3'd0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lock     <= 1'b0;
            lock_idx <= 1'b0;
            rr_ptr   <= 1'b0;
            beat_cnt <= 3'd0;
            for (int k = 0; k < 2; k++) begin
                inflight[k] <= 3'd0;
                d_cnt[k]    <= 3'd0;
            end
        end else begin
            if (a_fire) begin
                if (!lock) begin
                    rr_ptr <= ~grant;
                    if (a_beats_m1 != 3'd0) begin
                        lock     <= 1'b1;
                        lock_idx <= grant;
                        beat_cnt <= a_beats_m1;
                    end
                end else begin
                    beat_cnt <= beat_cnt - 3'd1;
                    if (beat_cnt == 3'd1) begin
                        lock <= 1'b0;
                    end
                end
            end
            for (int k = 0; k < 2; k++) begin
                inflight[k] <= inflight[k] + {2'b00, a_inc[k]} - {2'b00, d_dec[k]};
                if (d_fire[k]) begin
                    d_cnt[k] <= (d_cnt[k] == 3'd0) ? d_beats_m1 : d_cnt[k] - 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tl_client_arbiter.sv
// tb/tb_tl_client_arbiter.sv - directed self-checking bench for tl_client_arbiter
module tb_tl_client_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        a0_ready, a0_valid, a0_source;
    logic [2:0]  a0_opcode, a0_size;
    logic [35:0] a0_address;
    logic [7:0]  a0_mask;
    logic [63:0] a0_data;
    logic        d0_ready, d0_valid, d0_source;
    logic [2:0]  d0_opcode, d0_size;
    logic [63:0] d0_data;
    logic        a1_ready, a1_valid, a1_source;
    logic [2:0]  a1_opcode, a1_size;
    logic [35:0] a1_address;
    logic [7:0]  a1_mask;
    logic [63:0] a1_data;
    logic        d1_ready, d1_valid, d1_source;
    logic [2:0]  d1_opcode, d1_size;
    logic [63:0] d1_data;
    logic        oa_ready, oa_valid;
    logic [2:0]  oa_opcode, oa_size;
    logic [1:0]  oa_source;
    logic [35:0] oa_address;
    logic [7:0]  oa_mask;
    logic [63:0] oa_data;
    logic        od_ready, od_valid;
    logic [2:0]  od_opcode, od_size;
    logic [1:0]  od_source;
    logic [63:0] od_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    tl_client_arbiter #(.MAX_INFLIGHT(2)) dut (
        .clock(clock), .reset(reset),
        .auto_in_0_a_ready(a0_ready), .auto_in_0_a_valid(a0_valid),
        .auto_in_0_a_bits_opcode(a0_opcode), .auto_in_0_a_bits_size(a0_size),
        .auto_in_0_a_bits_source(a0_source), .auto_in_0_a_bits_address(a0_address),
        .auto_in_0_a_bits_mask(a0_mask), .auto_in_0_a_bits_data(a0_data),
        .auto_in_0_d_ready(d0_ready), .auto_in_0_d_valid(d0_valid),
        .auto_in_0_d_bits_opcode(d0_opcode), .auto_in_0_d_bits_size(d0_size),
        .auto_in_0_d_bits_source(d0_source), .auto_in_0_d_bits_data(d0_data),
        .auto_in_1_a_ready(a1_ready), .auto_in_1_a_valid(a1_valid),
        .auto_in_1_a_bits_opcode(a1_opcode), .auto_in_1_a_bits_size(a1_size),
        .auto_in_1_a_bits_source(a1_source), .auto_in_1_a_bits_address(a1_address),
        .auto_in_1_a_bits_mask(a1_mask), .auto_in_1_a_bits_data(a1_data),
        .auto_in_1_d_ready(d1_ready), .auto_in_1_d_valid(d1_valid),
        .auto_in_1_d_bits_opcode(d1_opcode), .auto_in_1_d_bits_size(d1_size),
        .auto_in_1_d_bits_source(d1_source), .auto_in_1_d_bits_data(d1_data),
        .auto_out_a_ready(oa_ready), .auto_out_a_valid(oa_valid),
        .auto_out_a_bits_opcode(oa_opcode), .auto_out_a_bits_size(oa_size),
        .auto_out_a_bits_source(oa_source), .auto_out_a_bits_address(oa_address),
        .auto_out_a_bits_mask(oa_mask), .auto_out_a_bits_data(oa_data),
        .auto_out_d_ready(od_ready), .auto_out_d_valid(od_valid),
        .auto_out_d_bits_opcode(od_opcode), .auto_out_d_bits_size(od_size),
        .auto_out_d_bits_source(od_source), .auto_out_d_bits_data(od_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        a0_valid = 0; a0_opcode = 3'd4; a0_size = 3'd3; a0_source = 0;
        a0_address = 36'h0; a0_mask = 8'hff; a0_data = 64'h0;
        a1_valid = 0; a1_opcode = 3'd4; a1_size = 3'd3; a1_source = 0;
        a1_address = 36'h0; a1_mask = 8'hff; a1_data = 64'h0;
        d0_ready = 0; d1_ready = 0; oa_ready = 0;
        od_valid = 0; od_opcode = 3'd0; od_size = 3'd3; od_source = 2'b00; od_data = 64'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        @(negedge clock);
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        reset = 1;
        @(negedge clock);
        // Reset gating: all handshake outputs low despite active inputs
        a0_valid = 1; a1_valid = 1; oa_ready = 1; od_valid = 1; d0_ready = 1; d1_ready = 1;
        #1;
        check("rst_out_a_valid", oa_valid, 0);
        check("rst_a0_ready", a0_ready, 0);
        check("rst_a1_ready", a1_ready, 0);
        check("rst_out_d_ready", od_ready, 0);
        check("rst_d0_valid", d0_valid, 0);
        @(negedge clock);
        clear_inputs();
        reset = 0;
        #1;
        check("rst_lock", dut.lock, 0);
        check("rst_rr_ptr", dut.rr_ptr, 0);
        check("rst_beat_cnt", dut.beat_cnt, 0);
        check("rst_inflight0", dut.inflight[0], 0);
        check("rst_inflight1", dut.inflight[1], 0);
        @(negedge clock);

        // 1: alternating Gets
        do_reset();
        a0_valid = 1; a0_source = 1; a1_valid = 1; a1_source = 0; oa_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t1_source", oa_source, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("t1_a0_ready", a0_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
            @(negedge clock);
        end
        #1;
        check("t1_both_limited", oa_valid, 0);
        @(negedge clock);

        // 2: 8-beat PutFull locks the channel, including a gap with no valid
        do_reset();
        a0_valid = 1; a0_opcode = 3'd0; a0_size = 3'd6; a0_address = 36'h1_0000_0040;
        a1_valid = 1; a1_source = 1; oa_ready = 1;
        for (int b = 0; b < 8; b++) begin
            if (b == 4) begin
                a0_valid = 0;
                #1;
                check("t2_gap_valid", oa_valid, 0);
                check("t2_gap_a1_ready", a1_ready, 0);
                check("t2_gap_lock", dut.lock, 1);
                @(negedge clock);
                a0_valid = 1;
            end
            a0_data = 64'hA000 + 64'(b);
            #1;
            check("t2_source", oa_source, 2'b00);
            check("t2_data", oa_data, 64'hA000 + 64'(b));
            check("t2_a0_ready", a0_ready, 1);
            check("t2_a1_ready", a1_ready, 0);
            @(negedge clock);
        end
        #1;
        check("t2_unlock", dut.lock, 0);
        check("t2_next_source", oa_source, 2'b11);
        check("t2_next_a1_ready", a1_ready, 1);
        @(negedge clock);

        // 3: in-flight limit on client 0, client 1 still served
        do_reset();
        a0_valid = 1; oa_ready = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t3_a0_ready", a0_ready, 1);
            @(negedge clock);
        end
        #1;
        check("t3_held_ready", a0_ready, 0);
        check("t3_held_valid", oa_valid, 0);
        check("t3_inflight0", dut.inflight[0], 2);
        @(negedge clock);
        a1_valid = 1; a1_source = 1;
        #1;
        check("t3_a1_ready", a1_ready, 1);
        check("t3_a1_source", oa_source, 2'b11);
        check("t3_a0_still_held", a0_ready, 0);
        @(negedge clock);

        // 4: 4-beat AccessAckData to client 1
        do_reset();
        a1_valid = 1; a1_source = 1; oa_ready = 1;
        repeat (2) @(negedge clock);
        #1;
        check("t4_inflight1_full", dut.inflight[1], 2);
        check("t4_a1_blocked", a1_ready, 0);
        od_valid = 1; od_opcode = 3'd1; od_size = 3'd5; od_source = 2'b11;
        d0_ready = 1; d1_ready = 0;
        #1;
        check("t4_stall_ready", od_ready, 0);
        check("t4_stall_d1_valid", d1_valid, 1);
        @(negedge clock);
        d1_ready = 1;
        for (int b = 0; b < 4; b++) begin
            od_data = 64'hD000 + 64'(b);
            #1;
            check("t4_d1_valid", d1_valid, 1);
            check("t4_d0_valid", d0_valid, 0);
            check("t4_d1_source", d1_source, 1);
            check("t4_d1_data", d1_data, 64'hD000 + 64'(b));
            check("t4_d1_opcode", d1_opcode, 3'd1);
            check("t4_out_d_ready", od_ready, 1);
            check("t4_inflight1_mid", dut.inflight[1], 2);
            check("t4_a1_mid_ready", a1_ready, 0);
            @(negedge clock);
        end
        od_valid = 0;
        #1;
        check("t4_inflight1_after", dut.inflight[1], 1);
        check("t4_a1_after_ready", a1_ready, 1);
        @(negedge clock);

        // 5: same-cycle A first beat and last D beat on client 0
        do_reset();
        a0_valid = 1; oa_ready = 1;
        @(negedge clock);
        #1;
        check("t5_inflight0_one", dut.inflight[0], 1);
        od_valid = 1; od_opcode = 3'd0; od_size = 3'd3; od_source = 2'b00; d0_ready = 1;
        #1;
        check("t5_d0_valid", d0_valid, 1);
        check("t5_d0_source", d0_source, 0);
        check("t5_a0_ready", a0_ready, 1);
        @(negedge clock);
        #1;
        check("t5_inflight0_net", dut.inflight[0], 1);
        a0_valid = 0;
        @(negedge clock);
        #1;
        check("t5_inflight0_dec", dut.inflight[0], 0);
        @(negedge clock);

        // 6: reset in the middle of an 8-beat Put
        do_reset();
        a0_valid = 1; a0_opcode = 3'd0; a0_size = 3'd6; a1_valid = 1; a1_source = 1; oa_ready = 1;
        repeat (3) @(negedge clock);
        #1;
        check("t6_lock_mid", dut.lock, 1);
        check("t6_beat_cnt_mid", dut.beat_cnt, 5);
        check("t6_rr_mid", dut.rr_ptr, 1);
        reset = 1;
        #1;
        check("t6_rst_a0_ready", a0_ready, 0);
        check("t6_rst_a1_ready", a1_ready, 0);
        check("t6_rst_out_valid", oa_valid, 0);
        @(negedge clock);
        #1;
        check("t6_lock_after", dut.lock, 0);
        check("t6_beat_cnt_after", dut.beat_cnt, 0);
        check("t6_rr_after", dut.rr_ptr, 0);
        check("t6_inflight0_after", dut.inflight[0], 0);
        reset = 0; a0_opcode = 3'd4; a0_size = 3'd3;
        #1;
        check("t6_regrant_source", oa_source, 2'b00);
        check("t6_regrant_a0_ready", a0_ready, 1);
        check("t6_regrant_a1_ready", a1_ready, 0);
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
